// File: rtl/ssd_sched_pkg.sv
// Shared types for the two-digit 7-segment display scheduler.
package ssd_sched_pkg;

   localparam int num_req = 2;

   typedef enum logic [0:0] {
      ARB  = 1'b0,
      SHOW = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0] left;
      logic [3:0] right;
   } disp_t;

   // Round-robin pointer only breaks ties; a lone requester always wins.
   function automatic logic pick_winner(input logic [num_req-1:0] valid,
                                        input logic               rr);
      if (valid == 2'b11) begin
         return rr;
      end
      return valid[1];
   endfunction

endpackage

// File: rtl/ssd_display_sched_if.sv
// Requester-side valid/ready bundle for the display scheduler.
interface ssd_display_sched_if;
   import ssd_sched_pkg::*;

   logic [num_req-1:0]   valid_i;
   logic [num_req*8-1:0] value_i;
   logic [num_req-1:0]   ready_o;

   modport master (output valid_i, output value_i, input ready_o);
   modport slave  (input valid_i, input value_i, output ready_o);

endinterface

// File: rtl/ssd_prescaler.sv
// Free-running digit-select generator: half-period counter, select toggle,
// one refresh tick per select 1->0 edge and a pulse on every select change.
module ssd_prescaler #(
   parameter int clk_freq_hz = 12000000,
   parameter int refresh_hz  = 50
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic digit_sel_o,
   output logic tick_o,
   output logic edge_o
);

   localparam int HALF_CYCLES = clk_freq_hz / (2 * refresh_hz);
   localparam int CNT_W       = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic             tick_q, tick_d;
   logic             edge_q, edge_d;
   logic             wrap;

   assign wrap = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      sel_d  = sel_q ^ wrap;
      tick_d = wrap & sel_q;
      edge_d = wrap;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q  <= '0;
         sel_q  <= 1'b0;
         tick_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sel_q  <= sel_d;
         tick_q <= tick_d;
         edge_q <= edge_d;
      end
   end

   assign digit_sel_o = sel_q;
   assign tick_o      = tick_q;
   assign edge_o      = edge_q;

endmodule

// File: rtl/ssd_display_sched.sv
// Round-robin display scheduler for the two-digit 7-segment PMOD.
// Optional anti-ghost blanking at select edges: define SSD_DEADTIME_EN.
module ssd_display_sched
   import ssd_sched_pkg::*;
#(
   parameter int clk_freq_hz     = 12000000,
   parameter int refresh_hz      = 50,
   parameter int hold_refreshes  = 25,
   parameter int deadtime_cycles = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   ssd_display_sched_if.slave   req,
   output logic                 digit_sel_o,
   output logic [3:0]           left_digit_o,
   output logic [3:0]           right_digit_o,
   output logic                 owner_o,
   output logic                 blank_o
);

   localparam int HOLD_W = (hold_refreshes > 1) ? $clog2(hold_refreshes) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(hold_refreshes - 1);

   logic                tick;
   logic                sel_edge;

   state_t              state_q, state_d;
   logic                rr_q, rr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   disp_t               disp_q, disp_d;
   logic                owner_q, owner_d;
   logic [num_req-1:0]  ready;
   logic                winner;

   ssd_prescaler #(
      .clk_freq_hz (clk_freq_hz),
      .refresh_hz  (refresh_hz)
   ) u_prescaler (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .digit_sel_o (digit_sel_o),
      .tick_o      (tick),
      .edge_o      (sel_edge)
   );

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      hold_d  = hold_q;
      disp_d  = disp_q;
      owner_d = owner_q;
      ready   = '0;
      winner  = pick_winner(req.valid_i, rr_q);
      unique case (state_q)
         ARB: begin
            if (|req.valid_i) begin
               ready[winner] = 1'b1;
               disp_d        = disp_t'(winner ? req.value_i[15:8] : req.value_i[7:0]);
               owner_d       = winner;
               rr_d          = ~winner;
               hold_d        = HOLD_LOAD;
               state_d       = SHOW;
            end
         end
         SHOW: begin
            // Hold is counted in whole refreshes, so only ticks advance it.
            if (tick) begin
               if (hold_q == '0) begin
                  state_d = ARB;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ARB;
         rr_q    <= 1'b0;
         hold_q  <= '0;
         disp_q  <= '0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         hold_q  <= hold_d;
         disp_q  <= disp_d;
         owner_q <= owner_d;
      end
   end

   assign req.ready_o   = ready;
   assign left_digit_o  = disp_q.left;
   assign right_digit_o = disp_q.right;
   assign owner_o       = owner_q;

`ifdef SSD_DEADTIME_EN
   localparam int DT_W = (deadtime_cycles > 1) ? $clog2(deadtime_cycles) : 1;
   localparam logic [DT_W-1:0] DT_LOAD = DT_W'((deadtime_cycles > 0) ? deadtime_cycles - 1 : 0);

   logic [DT_W-1:0] dt_q, dt_d;

   // The edge cycle itself is blanked; the counter covers the remaining cycles.
   always_comb begin
      dt_d = dt_q;
      if (sel_edge) begin
         dt_d = DT_LOAD;
      end else if (dt_q != '0) begin
         dt_d = dt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         dt_q <= '0;
      end else begin
         dt_q <= dt_d;
      end
   end

   assign blank_o = (deadtime_cycles > 0) && (sel_edge || (dt_q != '0));
`else
   localparam int unused_deadtime = deadtime_cycles;
   logic unused_edge;
   assign unused_edge = sel_edge;
   assign blank_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_display_sched.sv
// Randomised scoreboard bench for ssd_display_sched against a cycle-count model.
module tb_ssd_display_sched;
   import ssd_sched_pkg::*;

   localparam int CLK_HZ = 400;
   localparam int REF_HZ = 100;
   localparam int HOLD   = 2;
   localparam int DEAD   = 1;
   localparam int H      = CLK_HZ / (2 * REF_HZ);

   logic       clk = 1'b0;
   logic       reset_i;
   logic       digit_sel_o;
   logic [3:0] left_digit_o;
   logic [3:0] right_digit_o;
   logic       owner_o;
   logic       blank_o;

   int         tests = 0;
   int         fails = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp_last;

   ssd_display_sched_if bus ();

   ssd_display_sched #(
      .clk_freq_hz     (CLK_HZ),
      .refresh_hz      (REF_HZ),
      .hold_refreshes  (HOLD),
      .deadtime_cycles (DEAD)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .req           (bus),
      .digit_sel_o   (digit_sel_o),
      .left_digit_o  (left_digit_o),
      .right_digit_o (right_digit_o),
      .owner_o       (owner_o),
      .blank_o       (blank_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus and reference model: k is cycles since reset release.
   initial begin
      int         k;
      int         free_at;
      int         win;
      logic       rr;
      logic [1:0] pend;
      logic [1:0] v;
      logic [1:0] exp_rdy;
      logic [7:0] pval[2];

      reset_i     = 1'b1;
      bus.valid_i = '0;
      bus.value_i = '0;
      exp_last    = '0;
      pend        = '0;
      pval[0]     = '0;
      pval[1]     = '0;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      k       = 0;
      free_at = 0;
      rr      = 1'b0;

      for (int n = 0; n < 3000; n++) begin
         // Occasional reset while a value is being held.
         if (n >= 130 && k < free_at && $urandom_range(0, 59) == 0) begin
            reset_i     = 1'b1;
            bus.valid_i = '0;
            exp_q.delete();
            exp_last    = '0;
            @(negedge clk);
            reset_i = 1'b0;
            check("post_reset_digits", 32'({owner_o, left_digit_o, right_digit_o}), 0);
            check("post_reset_sel", 32'(digit_sel_o), 0);
            k       = 0;
            free_at = 0;
            rr      = 1'b0;
         end

         if (n == 12) begin
            pend    = 2'b11;
            pval[0] = 8'h11;
            pval[1] = 8'h22;
         end else if (n >= 60 && n < 130) begin
            if (!pend[1]) begin
               pend[1] = 1'b1;
               pval[1] = 8'($urandom);
            end
         end else if (n >= 130) begin
            for (int r = 0; r < 2; r++) begin
               if (!pend[r] && $urandom_range(0, 3) == 0) begin
                  pend[r] = 1'b1;
                  pval[r] = 8'($urandom);
               end else if (pend[r] && $urandom_range(0, 29) == 0) begin
                  pend[r] = 1'b0;
               end
            end
         end
         v           = pend;
         bus.valid_i = v;
         bus.value_i = {pval[1], pval[0]};
         #1;

         exp_rdy = '0;
         win     = 0;
         if (k >= free_at && v != 2'b00) begin
            win          = (v == 2'b11) ? int'(rr) : (v[1] ? 1 : 0);
            exp_rdy[win] = 1'b1;
         end
         check("ready", 32'(bus.ready_o), 32'(exp_rdy));
         check("digit_sel", 32'(digit_sel_o), (k / H) % 2);
`ifdef SSD_DEADTIME_EN
         check("blank", 32'(blank_o), 32'(k > 0 && (k % H) == 0));
`else
         check("blank", 32'(blank_o), 0);
`endif
         if (exp_rdy != 2'b00) begin
            exp_q.push_back({win[0], pval[win]});
            rr      = (win == 0);
            free_at = ((k / (2 * H)) + 1) * 2 * H + (HOLD - 1) * 2 * H + 1;
         end
         pend = pend & ~(bus.valid_i & bus.ready_o);
         k++;
         @(negedge clk);
      end
      bus.valid_i = '0;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Monitor: after each observed transfer the display must show the queued value.
   initial begin
      logic       xfer;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         #2;
         xfer = |(bus.valid_i & bus.ready_o);
         @(posedge clk);
         #1;
         if (xfer) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_transfer: got transfer expected none at %0t", $time);
            end else begin
               e        = exp_q.pop_front();
               exp_last = e;
            end
         end
         check("display", 32'({owner_o, left_digit_o, right_digit_o}), 32'(exp_last));
      end
   end

endmodule
